// File: rtl/reg_pair_incdec.sv
// reg_pair_incdec: INC/DEC rr read-modify-write sequencer feeding the 8-register file.
// Optional wrap flag port is enabled by defining REG_PAIR_WRAP_FLAG_EN.
module reg_pair_incdec (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_pair,
  input  logic        req_dec,
  output logic [2:0]  out1_sel,
  output logic [2:0]  out2_sel,
  input  logic [7:0]  out1,
  input  logic [7:0]  out2,
  output logic [2:0]  data_in_sel,
  output logic [7:0]  data_in,
  output logic        write_reg,
  output logic        done,
  output logic [15:0] result
`ifdef REG_PAIR_WRAP_FLAG_EN
  ,
  output logic        wrap
`endif
);
  typedef enum logic [2:0] {IDLE, READ, WR_LO, WR_HI, DONE} state_t;
  state_t state, state_n;
  logic [1:0]  pair_q;
  logic        dec_q;
  logic [15:0] sum;
  logic [15:0] rd;
  logic [2:0]  hi_sel, lo_sel;
  logic        accept;
  assign rd     = {out1, out2};
  assign accept = req_valid && req_ready;
  // pair 3 maps both halves onto the null register, so writes are dropped by the file
  assign hi_sel = (pair_q == 2'd3) ? 3'd6 : {pair_q, 1'b0};
  assign lo_sel = (pair_q == 2'd3) ? 3'd6 : {pair_q, 1'b1};
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end
  always_comb begin
    state_n = (state == IDLE)  ? (accept ? READ : IDLE) :
              (state == READ)  ? WR_LO :
              (state == WR_LO) ? WR_HI :
              (state == WR_HI) ? DONE  : IDLE;
  end
  always_comb begin
    req_ready   = (state == IDLE) && !reset;
    out1_sel    = (state == READ) ? hi_sel : 3'd6;
    out2_sel    = (state == READ) ? lo_sel : 3'd6;
    write_reg   = (state == WR_LO) || (state == WR_HI);
    data_in_sel = (state == WR_LO) ? lo_sel : (state == WR_HI) ? hi_sel : 3'd6;
    data_in     = (state == WR_LO) ? sum[7:0] : (state == WR_HI) ? sum[15:8] : 8'h00;
    done        = (state == DONE);
  end
`ifdef REG_PAIR_WRAP_FLAG_EN
  logic wrap_s;
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wrap_s <= 1'b0;
      wrap   <= 1'b0;
    end else begin
      if (state == READ) wrap_s <= dec_q ? (rd == 16'h0000) : (rd == 16'hFFFF);
      if (state == WR_HI) wrap <= wrap_s;
    end
  end
`endif
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pair_q <= 2'd3;
      dec_q  <= 1'b0;
      sum    <= 16'h0000;
      result <= 16'h0000;
    end else begin
      if (accept) begin
        pair_q <= req_pair;
        dec_q  <= req_dec;
      end
      if (state == READ) sum <= rd + (dec_q ? 16'hFFFF : 16'h0001);
      if (state == WR_HI) result <= sum;
    end
  end
endmodule

// File: tb/tb_reg_pair_incdec.sv
// tb_reg_pair_incdec: directed scoreboard bench with a behavioural 8-register file.
module tb_reg_pair_incdec;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_pair = 2'd0;
  logic        req_dec = 1'b0;
  logic [2:0]  out1_sel, out2_sel, data_in_sel;
  logic [7:0]  out1, out2, data_in;
  logic        write_reg, done;
  logic [15:0] result;
  logic        wrap;
  logic [7:0]  rf [8];
  logic [7:0]  exp_rf [8];
  logic        pl_we = 1'b0;
  logic [2:0]  pl_sel = 3'd0;
  logic [7:0]  pl_data = 8'h00;
  logic [16:0] sb [$];
  int          n_cmp = 0;
  int          n_bad = 0;

  reg_pair_incdec dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_pair(req_pair), .req_dec(req_dec), .out1_sel(out1_sel), .out2_sel(out2_sel),
    .out1(out1), .out2(out2), .data_in_sel(data_in_sel), .data_in(data_in),
    .write_reg(write_reg), .done(done), .result(result)
`ifdef REG_PAIR_WRAP_FLAG_EN
    , .wrap(wrap)
`endif
  );
`ifndef REG_PAIR_WRAP_FLAG_EN
  assign wrap = 1'b0;
`endif

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (pl_we) rf[pl_sel] <= pl_data;
    else if (write_reg && data_in_sel != 3'd6) rf[data_in_sel] <= data_in;
  end
  assign out1 = (out1_sel == 3'd6) ? 8'h00 : rf[out1_sel];
  assign out2 = (out2_sel == 3'd6) ? 8'h00 : rf[out2_sel];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    if (done) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_done: got done=1 expected no done at %0t", $time);
      end else begin
        logic [16:0] e;
        e = sb.pop_front();
        check("result", {16'h0, result}, {16'h0, e[15:0]});
`ifdef REG_PAIR_WRAP_FLAG_EN
        check("wrap", {31'h0, wrap}, {31'h0, e[16]});
`endif
      end
    end
  end

  task automatic check_regs();
    for (int i = 0; i < 8; i++) check($sformatf("rf[%0d]", i), {24'h0, rf[i]}, {24'h0, exp_rf[i]});
  endtask

  task automatic run_op(input logic [1:0] p, input logic d, input logic [15:0] res, input logic w);
    logic [2:0] hs, ls;
    hs = (p == 2'd3) ? 3'd6 : {p, 1'b0};
    ls = (p == 2'd3) ? 3'd6 : {p, 1'b1};
    @(negedge clock);
    check("ready_idle", {31'h0, req_ready}, 32'd1);
    req_valid = 1'b1; req_pair = p; req_dec = d;
    sb.push_back({w, res});
    for (int k = 1; k <= 5; k++) begin
      @(negedge clock);
      if (k == 1) begin
        req_valid = 1'b0; req_pair = ~p; req_dec = ~d;
        check("read_sel1", {29'h0, out1_sel}, {29'h0, hs});
        check("read_sel2", {29'h0, out2_sel}, {29'h0, ls});
      end
      check($sformatf("write_reg_c%0d", k), {31'h0, write_reg}, {31'h0, (k == 2 || k == 3)});
      check($sformatf("ready_c%0d", k), {31'h0, req_ready}, {31'h0, (k == 5)});
      if (k == 2) check("wr_lo_sel", {29'h0, data_in_sel}, {29'h0, ls});
      if (k == 3) check("wr_hi_sel", {29'h0, data_in_sel}, {29'h0, hs});
      if (k == 3 && p != 2'd3) begin
        check("lo_committed", {24'h0, rf[ls]}, {24'h0, res[7:0]});
        check("hi_not_yet", {24'h0, rf[hs]}, {24'h0, exp_rf[hs]});
      end
    end
    if (p != 2'd3) begin
      exp_rf[ls] = res[7:0];
      exp_rf[hs] = res[15:8];
    end
    check_regs();
  endtask

  initial begin
    logic [7:0] init [8];
    init = '{8'h12, 8'hFF, 8'h00, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h5A};
    repeat (3) @(negedge clock);
    check("rst_ready", {31'h0, req_ready}, 32'd0);
    check("rst_sel1", {29'h0, out1_sel}, 32'd6);
    check("rst_sel2", {29'h0, out2_sel}, 32'd6);
    check("rst_wsel", {29'h0, data_in_sel}, 32'd6);
    check("rst_data", {24'h0, data_in}, 32'd0);
    check("rst_we", {31'h0, write_reg}, 32'd0);
    check("rst_done", {31'h0, done}, 32'd0);
    check("rst_result", {16'h0, result}, 32'd0);
    check("rst_wrap", {31'h0, wrap}, 32'd0);
    reset = 1'b0;
    @(negedge clock);
    check("ready_after_rst", {31'h0, req_ready}, 32'd1);
    for (int i = 0; i < 8; i++) begin
      pl_we = 1'b1; pl_sel = 3'(i); pl_data = init[i]; exp_rf[i] = init[i];
      @(negedge clock);
    end
    pl_we = 1'b0;
    run_op(2'd0, 1'b0, 16'h1300, 1'b0);
    run_op(2'd2, 1'b1, 16'hFFFF, 1'b1);
    run_op(2'd3, 1'b0, 16'h0001, 1'b0);
    run_op(2'd2, 1'b0, 16'h0000, 1'b1);
    // back-to-back: valid held high, second request accepted as soon as IDLE returns
    @(negedge clock);
    req_valid = 1'b1; req_pair = 2'd1; req_dec = 1'b0;
    sb.push_back({1'b0, 16'h0100});
    sb.push_back({1'b0, 16'h00FF});
    for (int k = 1; k <= 10; k++) begin
      @(negedge clock);
      if (k == 1) req_dec = 1'b1;
      if (k == 6) req_valid = 1'b0;
      check($sformatf("b2b_done_c%0d", k), {31'h0, done}, {31'h0, (k == 4 || k == 9)});
      check($sformatf("b2b_ready_c%0d", k), {31'h0, req_ready}, {31'h0, (k == 5 || k == 10)});
    end
    check_regs();
    // reset lands in WR_HI: low byte already committed, high byte lost
    req_valid = 1'b1; req_pair = 2'd1; req_dec = 1'b0;
    @(negedge clock);
    req_valid = 1'b0;
    repeat (2) @(negedge clock);
    check("pre_rst_we", {31'h0, write_reg}, 32'd1);
    reset = 1'b1;
    #1;
    check("mid_rst_we", {31'h0, write_reg}, 32'd0);
    check("mid_rst_wsel", {29'h0, data_in_sel}, 32'd6);
    check("mid_rst_done", {31'h0, done}, 32'd0);
    check("mid_rst_result", {16'h0, result}, 32'd0);
    check("mid_rst_ready", {31'h0, req_ready}, 32'd0);
    @(negedge clock);
    exp_rf[3] = 8'h00;
    check_regs();
    reset = 1'b0;
    run_op(2'd1, 1'b0, 16'h0001, 1'b0);
    repeat (3) @(negedge clock);
    check("sb_empty", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
